// File: rtl/twiddle_fetch_sequencer_if.sv
// Twiddle word stream from the fetch sequencer to the butterfly datapath.
// The producer drives the head word, its stage tag and the end-of-sequence
// marker. The consumer drives tw_ready. A word moves on tw_valid & tw_ready.
interface twiddle_fetch_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGE_W    = 4
) ();
    logic [DATA_WIDTH-1:0] tw_data;
    logic                  tw_valid;
    logic                  tw_ready;
    logic [STAGE_W-1:0]    tw_stage;
    logic                  tw_last;

    modport master (
        output tw_data,
        output tw_valid,
        output tw_stage,
        output tw_last,
        input  tw_ready
    );

    modport slave (
        input  tw_data,
        input  tw_valid,
        input  tw_stage,
        input  tw_last,
        output tw_ready
    );
endinterface

// File: rtl/twiddle_fetch_sequencer.sv
// Twiddle fetch sequencer for a radix-2 DIT FFT.
// The block walks each stage s and each butterfly b. For every pair it issues
// the ROM address of twiddle index k = (b mod 2^s) << (LOG2N-1-s). A two-entry
// tag pipe follows the one-cycle registered ROM. Returned words go into a
// small FIFO, and the FIFO head drives the valid/ready stream.
// A new address is issued only when (FIFO occupancy + words in flight) is
// below FIFO_DEPTH. Every issued word therefore has a free slot when it
// arrives, and the ROM never needs to be stalled.
module twiddle_fetch_sequencer #(
    parameter int LOG2N      = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int ADDR_BASE  = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int STAGE_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_start,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [ADDR_WIDTH-1:0]     o_rom_addr,
    input  logic [DATA_WIDTH-1:0]     i_rom_data,
    twiddle_fetch_sequencer_if.master tw
);
    localparam int N_HALF = 1 << (LOG2N - 1);
    localparam int B_W    = (LOG2N > 1) ? (LOG2N - 1) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);
    localparam int USED_W = OCC_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    // Stage and butterfly counters for the next address to issue.
    logic [STAGE_W-1:0]    r_s;
    logic [B_W-1:0]        r_b;
    logic [ADDR_WIDTH-1:0] r_rom_addr;

    // Tag pipe. Stage 1 lines up with the ROM address and stage 2 lines up
    // with the ROM data.
    logic                  r_v1;
    logic                  r_v2;
    logic [STAGE_W-1:0]    r_s1;
    logic [STAGE_W-1:0]    r_s2;
    logic                  r_last1;
    logic                  r_last2;

    // Output FIFO.
    logic [DATA_WIDTH-1:0] r_mem_data  [FIFO_DEPTH];
    logic [STAGE_W-1:0]    r_mem_stage [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_mem_last;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [OCC_W-1:0]      r_occ;

    logic                  w_start_acc;
    logic                  w_issue;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_last_b;
    logic                  w_last_issue;
    logic                  w_nonempty;
    logic [1:0]            w_inflight;
    logic [USED_W-1:0]     w_used;
    logic [STAGE_W-1:0]    w_shamt;
    logic [ADDR_WIDTH-1:0] w_mask;
    logic [ADDR_WIDTH-1:0] w_k;
    logic [ADDR_WIDTH-1:0] w_addr;

    assign w_start_acc  = (r_state == ST_IDLE) && i_start;
    assign w_last_b     = (r_b == B_W'(N_HALF - 1));
    assign w_last_issue = w_last_b && (r_s == STAGE_W'(LOG2N - 1));
    assign w_inflight   = {1'b0, r_v1} + {1'b0, r_v2};
    assign w_used       = USED_W'(r_occ) + USED_W'(w_inflight);
    assign w_issue      = (r_state == ST_ISSUE) && (w_used < USED_W'(FIFO_DEPTH));
    assign w_nonempty   = (r_occ != OCC_W'(0));
    assign w_push       = r_v2;
    assign w_pop        = w_nonempty && tw.tw_ready;

    // Twiddle index and ROM address for the current stage and butterfly.
    always_comb begin
        w_shamt = STAGE_W'(LOG2N - 1) - r_s;
        w_mask  = (ADDR_WIDTH'(1) << r_s) - ADDR_WIDTH'(1);
        w_k     = (ADDR_WIDTH'(r_b) & w_mask) << w_shamt;
        w_addr  = ADDR_WIDTH'(ADDR_BASE) + w_k;
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode. start is only honoured in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (w_issue && w_last_issue) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (!w_nonempty && !r_v1 && !r_v2) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Stage/butterfly counters: clear on an accepted start, advance on each issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s <= STAGE_W'(0);
            r_b <= B_W'(0);
        end else if (w_start_acc) begin
            r_s <= STAGE_W'(0);
            r_b <= B_W'(0);
        end else if (w_issue) begin
            if (w_last_b) begin
                r_b <= B_W'(0);
                r_s <= r_s + STAGE_W'(1);
            end else begin
                r_b <= r_b + B_W'(1);
            end
        end
    end

    // ROM address register. It holds the last issued address between issues.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rom_addr <= ADDR_WIDTH'(0);
        end else if (w_issue) begin
            r_rom_addr <= w_addr;
        end
    end

    // Tag pipe. Carries stage and last marker alongside the ROM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_s1    <= STAGE_W'(0);
            r_last1 <= 1'b0;
            r_v2    <= 1'b0;
            r_s2    <= STAGE_W'(0);
            r_last2 <= 1'b0;
        end else begin
            r_v1    <= w_issue;
            r_s1    <= r_s;
            r_last1 <= w_last_issue;
            r_v2    <= r_v1;
            r_s2    <= r_s1;
            r_last2 <= r_last1;
        end
    end

    // FIFO storage. Writes the ROM word and its tag when the pipe delivers one.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i]  <= DATA_WIDTH'(0);
                r_mem_stage[i] <= STAGE_W'(0);
            end
            r_mem_last <= FIFO_DEPTH'(0);
        end else if (w_push) begin
            r_mem_data[r_wr_ptr]  <= i_rom_data;
            r_mem_stage[r_wr_ptr] <= r_s2;
            r_mem_last[r_wr_ptr]  <= r_last2;
        end
    end

    // FIFO pointers and occupancy. A simultaneous push and pop leaves occupancy unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= PTR_W'(0);
            r_rd_ptr <= PTR_W'(0);
            r_occ    <= OCC_W'(0);
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Stream outputs. The head fields read as zero whenever the FIFO is empty.
    always_comb begin
        tw.tw_valid = w_nonempty;
        if (w_nonempty) begin
            tw.tw_data  = r_mem_data[r_rd_ptr];
            tw.tw_stage = r_mem_stage[r_rd_ptr];
            tw.tw_last  = r_mem_last[r_rd_ptr];
        end else begin
            tw.tw_data  = DATA_WIDTH'(0);
            tw.tw_stage = STAGE_W'(0);
            tw.tw_last  = 1'b0;
        end
    end

    assign o_busy     = (r_state != ST_IDLE);
    assign o_done     = (r_state == ST_DONE);
    assign o_rom_addr = r_rom_addr;

endmodule
